// File: rtl/jtag_tap_ctrl_if.sv
// jtag_tap_ctrl_if: pin-side and chain-side signals of the JTAG TAP controller
interface jtag_tap_ctrl_if #(
    parameter int IR_WIDTH = 4,
    parameter int NUM_USER = 2
);
    logic                tms;
    logic                tdi;
    logic                tdo;
    logic                tdo_en;
    logic [IR_WIDTH-1:0] ir_out;
    logic                test_logic_reset;
    logic [NUM_USER-1:0] user_sel;
    logic                capture_dr;
    logic                shift_dr;
    logic                update_dr;
    logic [NUM_USER-1:0] tdo_user;

    modport master (
        output tms, tdi, tdo_user,
        input  tdo, tdo_en, ir_out, test_logic_reset, user_sel, capture_dr, shift_dr, update_dr
    );

    modport slave (
        input  tms, tdi, tdo_user,
        output tdo, tdo_en, ir_out, test_logic_reset, user_sel, capture_dr, shift_dr, update_dr
    );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP state machine with IR, BYPASS, IDCODE and user-chain TDO mux
module jtag_tap_ctrl #(
    parameter int          IR_WIDTH      = 4,
    parameter logic [31:0] IDCODE_VALUE  = 32'h1000_0001,
    parameter int          IDCODE_OPCODE = 1,
    parameter int          NUM_USER      = 2,
    parameter int          USER_BASE     = 8
) (
    input  logic            tck,
    input  logic            trst_n,
    jtag_tap_ctrl_if.slave  jtag
);
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } state_t;

    localparam logic [IR_WIDTH-1:0] ID_OP = IR_WIDTH'(IDCODE_OPCODE);

    state_t              state_q, state_d;
    logic [IR_WIDTH-1:0] ir_sr_q, ir_q, ir_out_w;
    logic [31:0]         id_sr_q;
    logic                bypass_q, tdo_q, tdo_en_q, is_id, dr_bit;
    logic [NUM_USER-1:0] user_sel_w;

    // TAP state register
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) state_q <= TLR;
        else         state_q <= state_d;
    end

    // 1149.1 TMS transition table
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:    state_d = jtag.tms ? TLR    : RTI;
            RTI:    state_d = jtag.tms ? SEL_DR : RTI;
            SEL_DR: state_d = jtag.tms ? SEL_IR : CAP_DR;
            CAP_DR: state_d = jtag.tms ? EX1_DR : SH_DR;
            SH_DR:  state_d = jtag.tms ? EX1_DR : SH_DR;
            EX1_DR: state_d = jtag.tms ? UPD_DR : PA_DR;
            PA_DR:  state_d = jtag.tms ? EX2_DR : PA_DR;
            EX2_DR: state_d = jtag.tms ? UPD_DR : SH_DR;
            UPD_DR: state_d = jtag.tms ? SEL_DR : RTI;
            SEL_IR: state_d = jtag.tms ? TLR    : CAP_IR;
            CAP_IR: state_d = jtag.tms ? EX1_IR : SH_IR;
            SH_IR:  state_d = jtag.tms ? EX1_IR : SH_IR;
            EX1_IR: state_d = jtag.tms ? UPD_IR : PA_IR;
            PA_IR:  state_d = jtag.tms ? EX2_IR : PA_IR;
            EX2_IR: state_d = jtag.tms ? UPD_IR : SH_IR;
            UPD_IR: state_d = jtag.tms ? SEL_DR : RTI;
        endcase
    end

    // Instruction decode; the forced opcode in TLR makes the reload visible on the entering edge
    always_comb begin
        ir_out_w = state_q == TLR ? ID_OP : ir_q;
        is_id    = ir_out_w == ID_OP;
        for (int k = 0; k < NUM_USER; k++)
            user_sel_w[k] = !is_id && ir_out_w == IR_WIDTH'(USER_BASE + k);
        dr_bit = |user_sel_w ? |(user_sel_w & jtag.tdo_user) : is_id ? id_sr_q[0] : bypass_q;
    end

    // Capture/shift of the IR and internal DR shift registers; they hold in Exit/Pause
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            ir_sr_q  <= '0;
            id_sr_q  <= '0;
            bypass_q <= 1'b0;
        end else begin
            if (state_q == CAP_IR)     ir_sr_q <= IR_WIDTH'(1);
            else if (state_q == SH_IR) ir_sr_q <= {jtag.tdi, ir_sr_q[IR_WIDTH-1:1]};
            if (state_q == CAP_DR) begin
                id_sr_q  <= IDCODE_VALUE;
                bypass_q <= 1'b0;
            end else if (state_q == SH_DR) begin
                id_sr_q  <= {jtag.tdi, id_sr_q[31:1]};
                bypass_q <= jtag.tdi;
            end
        end
    end

    // Falling-edge IR update and TDO retiming
    always_ff @(negedge tck or negedge trst_n) begin
        if (!trst_n) begin
            ir_q     <= ID_OP;
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            ir_q     <= state_q == UPD_IR ? ir_sr_q : state_q == TLR ? ID_OP : ir_q;
            tdo_en_q <= state_q == SH_IR || state_q == SH_DR;
            tdo_q    <= state_q == SH_IR ? ir_sr_q[0] : state_q == SH_DR ? dr_bit : tdo_q;
        end
    end

    assign jtag.tdo              = tdo_q;
    assign jtag.tdo_en           = tdo_en_q;
    assign jtag.ir_out           = ir_out_w;
    assign jtag.test_logic_reset = state_q == TLR;
    assign jtag.user_sel         = user_sel_w;
    assign jtag.capture_dr       = state_q == CAP_DR && |user_sel_w;
    assign jtag.shift_dr         = state_q == SH_DR && |user_sel_w;
    assign jtag.update_dr        = state_q == UPD_DR && |user_sel_w;
endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: random and directed TAP stimulus checked against a queue-based reference model
module tb_jtag_tap_ctrl;
    localparam int          IRW  = 4;
    localparam int          IDOP = 1;
    localparam int          NU   = 2;
    localparam int          UB   = 8;
    localparam logic [31:0] IDV  = 32'h1000_0001;

    localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7, UDR = 8;
    localparam int SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

    int nxt0 [16] = '{RTI, RTI, CDR, SHDR, SHDR, PDR, PDR, SHDR, RTI, CIR, SHIR, SHIR, PIR, PIR, SHIR, RTI};
    int nxt1 [16] = '{TLR, SDR, SIR, E1DR, E1DR, UDR, E2DR, UDR, SDR, TLR, E1IR, E1IR, UIR, E2IR, UIR, SDR};

    logic tck = 1'b0;
    logic trst_n = 1'b1;

    jtag_tap_ctrl_if #(.IR_WIDTH(IRW), .NUM_USER(NU)) jif ();

    jtag_tap_ctrl #(
        .IR_WIDTH(IRW), .IDCODE_VALUE(IDV), .IDCODE_OPCODE(IDOP), .NUM_USER(NU), .USER_BASE(UB)
    ) dut (
        .tck(tck), .trst_n(trst_n), .jtag(jif)
    );

    always #10 tck = ~tck;

    int          n_chk = 0, n_err = 0;
    int          ms, m_ir;
    logic        m_tdo, m_en;
    bit          q [$];
    logic [31:0] idv = IDV;
    logic [31:0] cap_v;
    int          ncap, n_cap, n_sh, n_upd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int uidx(input int ir);
        return (ir != IDOP && ir >= UB && ir < UB + NU) ? ir - UB : -1;
    endfunction

    task automatic model_rise(input logic t, input logic d);
        int uk = uidx(m_ir);
        if (ms == CIR) begin
            q.delete();
            for (int i = 0; i < IRW; i++) q.push_back(i == 0);
        end else if (ms == SHIR || (ms == SHDR && uk < 0)) begin
            void'(q.pop_front());
            q.push_back(d);
        end else if (ms == CDR) begin
            q.delete();
            if (uk < 0 && m_ir == IDOP) for (int i = 0; i < 32; i++) q.push_back(idv[i]);
            else if (uk < 0) q.push_back(1'b0);
        end
        ms = t ? nxt1[ms] : nxt0[ms];
        if (ms == TLR) m_ir = IDOP;
    endtask

    task automatic model_fall();
        int uk = uidx(m_ir);
        m_en = ms == SHIR || ms == SHDR;
        if (ms == SHIR) m_tdo = q[0];
        else if (ms == SHDR) m_tdo = uk >= 0 ? jif.tdo_user[uk] : q[0];
        if (ms == UIR) begin
            m_ir = 0;
            for (int i = 0; i < IRW; i++) m_ir = m_ir | (int'(q[i]) << i);
        end
    endtask

    task automatic check_all(input string tag);
        int uk = uidx(m_ir);
        logic u = uk >= 0;
        chk({tag, ".tlr"}, 32'(jif.test_logic_reset), 32'(ms == TLR));
        chk({tag, ".ir"}, 32'(jif.ir_out), 32'(m_ir));
        chk({tag, ".sel"}, 32'(jif.user_sel), u ? 32'(1) << uk : 32'd0);
        chk({tag, ".cap"}, 32'(jif.capture_dr), 32'(ms == CDR && u));
        chk({tag, ".sh"}, 32'(jif.shift_dr), 32'(ms == SHDR && u));
        chk({tag, ".upd"}, 32'(jif.update_dr), 32'(ms == UDR && u));
        chk({tag, ".en"}, 32'(jif.tdo_en), 32'(m_en));
        chk({tag, ".tdo"}, 32'(jif.tdo), 32'(m_tdo));
    endtask

    task automatic step(input logic t, input logic d);
        jif.tms = t;
        jif.tdi = d;
        jif.tdo_user = 2'($urandom_range(0, 3));
        @(posedge tck);
        model_rise(t, d);
        @(negedge tck);
        model_fall();
        #1;
        check_all("step");
        if (ms == SHDR || ms == SHIR) begin
            if (ncap < 32) cap_v[ncap] = jif.tdo;
            ncap++;
        end
        n_cap += int'(jif.capture_dr);
        n_sh  += int'(jif.shift_dr);
        n_upd += int'(jif.update_dr);
    endtask

    task automatic do_reset();
        #1 trst_n = 1'b0;
        ms = TLR; m_ir = IDOP; q.delete(); m_tdo = 1'b0; m_en = 1'b0;
        #2 check_all("rst");
        #2 trst_n = 1'b1;
    endtask

    task automatic load_ir(input logic [31:0] val);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < IRW; i++) step(i == IRW - 1, val[i]);
        step(1, 0); step(0, 0);
    endtask

    initial begin
        jif.tms = 1'b1; jif.tdi = 1'b0; jif.tdo_user = '0;
        @(negedge tck); #1;
        do_reset();
        step(0, 0);

        load_ir(9);
        chk("t5.sel9", 32'(jif.user_sel), 32'b10);
        n_cap = 0; n_sh = 0; n_upd = 0;
        step(1, 0); step(0, 0); step(0, 0); step(1, 0); step(1, 0); step(0, 0);
        chk("t5.ncap", n_cap, 1); chk("t5.nsh", n_sh, 1); chk("t5.nupd", n_upd, 1);
        load_ir(3);
        n_cap = 0; n_sh = 0; n_upd = 0;
        step(1, 0); step(0, 0); step(0, 0); step(1, 0); step(1, 0); step(0, 0);
        chk("t5.ncap3", n_cap, 0); chk("t5.nsh3", n_sh, 0); chk("t5.nupd3", n_upd, 0);

        load_ir(9);
        step(1, 0); step(0, 0); step(0, 1); step(0, 1);
        do_reset();
        chk("t1.tlr", 32'(jif.test_logic_reset), 1); chk("t1.ir", 32'(jif.ir_out), 1);
        chk("t1.en", 32'(jif.tdo_en), 0); chk("t1.sel", 32'(jif.user_sel), 0);

        step(0, 0); step(1, 0); step(0, 0);
        ncap = 0;
        step(0, 0);
        for (int i = 1; i < 32; i++) step(0, 1'($urandom_range(0, 1)));
        chk("t3.en", 32'(jif.tdo_en), 1);
        step(1, 0);
        chk("t3.endrop", 32'(jif.tdo_en), 0);
        chk("t3.idcode", cap_v, 32'h1000_0001);
        step(1, 0); step(0, 0);

        ncap = 0;
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        step(0, 1); step(0, 1); step(0, 1); step(1, 1);
        step(1, 0);
        chk("t4.irbits", 32'(cap_v[3:0]), 32'b0001);
        chk("t4.ir", 32'(jif.ir_out), 32'hF);
        step(0, 0);
        ncap = 0;
        step(1, 0); step(0, 0); step(0, 0);
        step(0, 1); step(0, 0); step(0, 1); step(1, 1);
        step(1, 0); step(0, 0);
        chk("t4.bypass", 32'(cap_v[3:0]), 32'b1010);

        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0);
            chk("t2.notyet", 32'(jif.test_logic_reset), 0);
        end
        step(1, 0);
        chk("t2.tlr", 32'(jif.test_logic_reset), 1);
        chk("t2.ir", 32'(jif.ir_out), IDOP);

        step(0, 0); step(1, 0); step(0, 0);
        ncap = 0;
        step(0, 0);
        for (int i = 1; i < 10; i++) step(0, 0);
        step(1, 0);
        for (int i = 0; i < 10; i++) step(0, 0);
        step(1, 0); step(0, 0);
        for (int i = 11; i < 32; i++) step(0, 0);
        step(1, 0);
        chk("t6.ncap", ncap, 32);
        chk("t6.idcode", cap_v, 32'h1000_0001);
        step(1, 0); step(0, 0);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            else step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
- Parametrised IEEE 1149.1 TAP controller: 16-state TMS machine plus an instruction register, BYPASS and IDCODE data registers, decoded user-chain selects and a registered TDO output.
- Successor to the fixed 4-bit-state controller with IR/DR strobes only. This block owns IR shifting, instruction decode and TDO muxing.
- Sits between the chip JTAG pins and the user scan chains (debug, boundary, config).

Parameters:
- IR_WIDTH, 4, instruction register width (>=2).
- IDCODE_VALUE, 32'h1000_0001, value captured by IDCODE; bit0 must be 1.
- IDCODE_OPCODE, 1, IR opcode selecting IDCODE.
- NUM_USER, 2, number of external user data chains (1..8).
- USER_BASE, 8, opcode of user chain 0; chain k uses USER_BASE+k.

Ports:
- tck  in  1  JTAG test clock, the only clock.
- trst_n  in  1  asynchronous active-low reset.
- tms  in  1  state control, sampled on tck rising edge.
- tdi  in  1  serial data in, sampled on tck rising edge.
- tdo  out  1  serial data out, changes on tck falling edge.
- tdo_en  out  1  output enable for the tdo pad, changes on tck falling edge.
- ir_out  out  IR_WIDTH  current (updated) instruction.
- test_logic_reset  out  1  high while in Test-Logic-Reset.
- user_sel  out  NUM_USER  one-hot select of the active user chain; all zero otherwise.
- capture_dr  out  1  high in Capture-DR, gated by any user_sel bit.
- shift_dr  out  1  high in Shift-DR, gated by any user_sel bit.
- update_dr  out  1  high in Update-DR, gated by any user_sel bit.
- tdo_user  in  NUM_USER  serial outputs of the user chains.

Behaviour:
- State machine:
  - States: Test-Logic-Reset, Run-Test/Idle, Select-DR/IR, Capture-DR/IR, Shift-DR/IR, Exit1-DR/IR, Pause-DR/IR, Exit2-DR/IR, Update-DR/IR.
  - Transitions follow 1149.1 exactly, on tck rising edge.
  - Five consecutive tms=1 edges reach Test-Logic-Reset from any state.
- Reset:
  - trst_n low forces state=Test-Logic-Reset, ir_out=IDCODE_OPCODE, IR shift reg=0, DR shift regs=0, tdo=0, tdo_en=0, test_logic_reset=1.
  - trst_n is asynchronous and applies mid-shift too; all partial shift data is discarded.
  - While in Test-Logic-Reset, ir_out is also reloaded with IDCODE_OPCODE on each tck rising edge.
- Instruction register:
  - Capture-IR (rising edge): shift reg <= {0..0,2'b01}.
  - Shift-IR (rising edge): shift right, tdi into the MSB; the serial output is the LSB.
  - Update-IR (falling edge of tck): ir_out <= shift reg.
  - ir_out is stable in every other state.
- Decode of ir_out:
  - IDCODE_OPCODE selects IDCODE.
  - USER_BASE..USER_BASE+NUM_USER-1 selects user chain k: user_sel[k]=1.
  - Every other opcode, including all-ones, selects BYPASS.
  - Decode is combinational from ir_out.
- BYPASS register: 1 bit. Captures 0 in Capture-DR and loads tdi in Shift-DR, giving exactly one tck of delay tdi->tdo.
- IDCODE register: 32 bits. Captures IDCODE_VALUE in Capture-DR, then shifts right with tdi into bit31 and LSB out.
- User chains:
  - capture_dr, shift_dr and update_dr are asserted only while a user opcode is active; they are combinational from state.
  - The user chain provides tdo_user[k] valid before the tck falling edge.
- TDO path:
  - On the tck falling edge, tdo <= selected serial bit: IR LSB in Shift-IR; BYPASS/IDCODE LSB/tdo_user[k] in Shift-DR.
  - On the same edge, tdo_en <= 1 in Shift-IR/Shift-DR and 0 elsewhere. tdo holds its value when tdo_en=0.
- Exit/Pause states: all shift registers hold.
- Simultaneous events: trst_n assertion dominates any tck edge.
- Timing: no combinational path from tdi to tdo.

Test Plan:
1. trst_n low mid Shift-DR, then release -> state Test-Logic-Reset, ir_out=1, tdo_en=0, test_logic_reset=1, user_sel=0.
2. From Shift-IR, five tms=1 edges -> Test-Logic-Reset reached on the 5th edge, ir_out=IDCODE_OPCODE.
3. After reset, go to Shift-DR and shift 32 bits -> tdo sequence LSB-first equals 32'h1000_0001; tdo_en=1 throughout and drops on the falling edge after Exit1-DR.
4. Shift IR_WIDTH bits of 4'b1111 -> captured bits out first are 1,0,0,0. After Update-IR, ir_out=4'hF (BYPASS); Shift-DR with tdi=1,0,1,1 gives tdo 0,1,0,1.
5. Load IR=9 -> user_sel=2'b10. In Shift-DR, tdo follows tdo_user[1]; capture_dr/shift_dr/update_dr pulse exactly one state each. With IR=3 (undefined), all three stay 0.
6. Pause-DR for 10 tck during an IDCODE shift, then resume via Exit2-DR -> the remaining bits continue with no loss or duplication.
